// File: rtl/blue_motion.sv
`default_nettype none
// ============================================================================
//  Module      : blue_motion
//  Description : Per-frame motion controller for the blue character
//                (47x41 sprite). Walk, jump, gravity fall and landing,
//                driven by keyboard levels and the collision vector.
//  Revision    : 1.0  initial release
// ============================================================================
module blue_motion #(
  parameter logic [9:0] X_START = 10'd40,
  parameter logic [8:0] Y_START = 9'd100,
  parameter logic [9:0] X_STEP  = 10'd2,
  parameter logic [4:0] JUMP_V  = 5'd12,
  parameter logic [4:0] GRAVITY = 5'd1,
  parameter logic [4:0] V_MAX   = 5'd10,
  parameter logic [9:0] X_MIN   = 10'd0,
  parameter logic [9:0] X_MAX   = 10'd593,
  parameter logic [8:0] Y_MAX   = 9'd439
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic [3:0] is_Collision,
  output logic [9:0] x_blue,
  output logic [8:0] y_blue,
  output logic [1:0] state,
  output logic [4:0] vy
);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } state_t;

  // Collision bit positions
  localparam int c_COL_DOWN  = 0;
  localparam int c_COL_UP    = 1;
  localparam int c_COL_RIGHT = 2;
  localparam int c_COL_LEFT  = 3;

  state_t     r_state;
  logic [9:0] r_x;
  logic [8:0] r_y;
  logic [4:0] r_vy;

  logic        w_move_right;
  logic        w_move_left;
  logic [10:0] w_x_right_sum;
  logic [9:0]  w_x_right;
  logic [9:0]  w_x_left;
  logic [9:0]  w_y_ext;
  logic [9:0]  w_vy_ext;
  logic [9:0]  w_y_fall_sum;
  logic        w_fall_hits_floor;
  logic        w_rise_ends;
  logic [8:0]  w_y_rise_sat;
  logic [8:0]  w_y_jump;
  logic [5:0]  w_vy_inc;
  logic [4:0]  w_vy_fall_next;

  // Candidate next positions/speeds; all y math done 10 bits wide so that
  // nothing wraps before the clamps are applied.
  always_comb begin
    w_move_right  = key_right & ~key_left & ~is_Collision[c_COL_RIGHT];
    w_move_left   = key_left & ~key_right & ~is_Collision[c_COL_LEFT];
    w_x_right_sum = {1'b0, r_x} + {1'b0, X_STEP};
    w_x_right     = (w_x_right_sum >= {1'b0, X_MAX}) ? X_MAX : w_x_right_sum[9:0];
    w_x_left      = (r_x < (X_MIN + X_STEP)) ? X_MIN : (r_x - X_STEP);

    w_y_ext           = {1'b0, r_y};
    w_vy_ext          = {5'd0, r_vy};
    w_y_fall_sum      = w_y_ext + w_vy_ext;
    w_fall_hits_floor = (w_y_fall_sum >= {1'b0, Y_MAX});
    w_rise_ends       = (r_vy <= GRAVITY) || (w_vy_ext >= w_y_ext);
    w_y_rise_sat      = (w_vy_ext >= w_y_ext) ? 9'd0 : (r_y - {4'd0, r_vy});
    w_y_jump          = (w_y_ext >= {5'd0, JUMP_V}) ? (r_y - {4'd0, JUMP_V}) : 9'd0;
    w_vy_inc          = {1'b0, r_vy} + {1'b0, GRAVITY};
    w_vy_fall_next    = (w_vy_inc >= {1'b0, V_MAX}) ? V_MAX : w_vy_inc[4:0];
  end

  // Position and vertical FSM; everything advances only on a frame tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= X_START;
      r_y     <= Y_START;
      r_state <= ST_FALL;
      r_vy    <= 5'd0;
    end else if (frame_tick) begin
      if (w_move_right) begin
        r_x <= w_x_right;
      end else if (w_move_left) begin
        r_x <= w_x_left;
      end

      case (r_state)
        ST_GROUND: begin
          if (!is_Collision[c_COL_DOWN] && (r_y < Y_MAX)) begin
            // Walked off a ledge: drop with zero initial speed
            r_state <= ST_FALL;
            r_vy    <= 5'd0;
          end else if (key_jump && !is_Collision[c_COL_UP]) begin
            r_state <= ST_RISE;
            r_vy    <= JUMP_V - GRAVITY;
            r_y     <= w_y_jump;
          end else begin
            r_vy <= 5'd0;
          end
        end
        ST_RISE: begin
          if (is_Collision[c_COL_UP]) begin
            // Head bump: stop where we are
            r_state <= ST_FALL;
            r_vy    <= 5'd0;
          end else if (w_rise_ends) begin
            r_state <= ST_FALL;
            r_vy    <= 5'd0;
            r_y     <= w_y_rise_sat;
          end else begin
            r_y  <= r_y - {4'd0, r_vy};
            r_vy <= r_vy - GRAVITY;
          end
        end
        ST_FALL: begin
          if (is_Collision[c_COL_DOWN]) begin
            r_state <= ST_GROUND;
            r_vy    <= 5'd0;
          end else if (w_fall_hits_floor) begin
            r_state <= ST_GROUND;
            r_y     <= Y_MAX;
            r_vy    <= 5'd0;
          end else begin
            r_y  <= w_y_fall_sum[8:0];
            r_vy <= w_vy_fall_next;
          end
        end
        default: begin
          // Unused encoding: recover into a clean fall
          r_state <= ST_FALL;
          r_vy    <= 5'd0;
        end
      endcase
    end
  end

  assign x_blue = r_x;
  assign y_blue = r_y;
  assign state  = r_state;
  assign vy     = r_vy;

endmodule
`default_nettype wire

// File: tb/tb_blue_motion.sv
`default_nettype none
// ============================================================================
//  Module      : tb_blue_motion
//  Description : Scoreboard bench for blue_motion. Each frame tick pushes the
//                reference model's prediction; the result is popped and
//                compared one edge later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_blue_motion;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       key_left;
  logic       key_right;
  logic       key_jump;
  logic [3:0] is_Collision;
  logic [9:0] x_blue;
  logic [8:0] y_blue;
  logic [1:0] state;
  logic [4:0] vy;

  blue_motion dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .key_left     (key_left),
    .key_right    (key_right),
    .key_jump     (key_jump),
    .is_Collision (is_Collision),
    .x_blue       (x_blue),
    .y_blue       (y_blue),
    .state        (state),
    .vy           (vy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int c_GROUND = 0;
  localparam int c_RISE   = 1;
  localparam int c_FALL   = 2;

  typedef struct {
    int x;
    int y;
    int st;
    int vy;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int mx, my, ms, mvy;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 40; my = 100; ms = c_FALL; mvy = 0;
  endtask

  task automatic model_step(input bit l, input bit r, input bit j, input bit [3:0] col);
    if (r && !l && !col[2]) mx = (mx + 2 > 593) ? 593 : mx + 2;
    else if (l && !r && !col[3]) mx = (mx - 2 < 0) ? 0 : mx - 2;
    case (ms)
      c_GROUND: begin
        if (!col[0] && my < 439) begin
          ms = c_FALL; mvy = 0;
        end else if (j && !col[1]) begin
          ms = c_RISE; mvy = 11; my = (my - 12 < 0) ? 0 : my - 12;
        end else mvy = 0;
      end
      c_RISE: begin
        if (col[1]) begin
          ms = c_FALL; mvy = 0;
        end else if (mvy <= 1 || mvy >= my) begin
          my = (my - mvy < 0) ? 0 : my - mvy;
          ms = c_FALL; mvy = 0;
        end else begin
          my = my - mvy; mvy = mvy - 1;
        end
      end
      default: begin
        if (col[0]) begin
          ms = c_GROUND; mvy = 0;
        end else if (my + mvy >= 439) begin
          ms = c_GROUND; my = 439; mvy = 0;
        end else begin
          my = my + mvy; mvy = (mvy + 1 > 10) ? 10 : mvy + 1;
        end
      end
    endcase
  endtask

  task automatic compare_outputs(input string tag, input exp_t e);
    check({tag, ".x"},  int'(x_blue), e.x);
    check({tag, ".y"},  int'(y_blue), e.y);
    check({tag, ".st"}, int'(state),  e.st);
    check({tag, ".vy"}, int'(vy),     e.vy);
  endtask

  // One frame tick: drive, predict, then pop and compare after the edge
  task automatic do_tick(input string tag, input bit l, input bit r, input bit j,
                         input bit [3:0] col);
    exp_t e;
    @(negedge clk);
    key_left = l; key_right = r; key_jump = j; is_Collision = col;
    frame_tick = 1'b1;
    model_step(l, r, j, col);
    e = '{mx, my, ms, mvy};
    sb.push_back(e);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    e = sb.pop_front();
    compare_outputs(tag, e);
    @(posedge clk);
  endtask

  int fall_y[5]  = '{100, 101, 103, 106, 110};
  int fall_vy[5] = '{1, 2, 3, 4, 5};

  initial begin
    exp_t hold;
    rst = 1'b1; frame_tick = 1'b0; key_left = 1'b0; key_right = 1'b0;
    key_jump = 1'b0; is_Collision = 4'd0;
    model_reset();
    @(posedge clk); #1;
    compare_outputs("reset", '{40, 100, c_FALL, 0});
    @(negedge clk); rst = 1'b0;

    // Free fall from reset height
    for (int i = 0; i < 5; i++) begin
      do_tick("fall", 0, 0, 0, 4'b0000);
      check("fall_y_const", int'(y_blue), fall_y[i]);
      check("fall_vy_const", int'(vy), fall_vy[i]);
    end

    // Landing on a platform
    do_tick("land", 0, 0, 0, 4'b0001);
    check("land_st_const", int'(state), c_GROUND);
    check("land_y_const", int'(y_blue), 110);
    do_tick("ground_idle", 0, 0, 0, 4'b0001);

    // Jump then immediate head bump
    do_tick("jump", 0, 0, 1, 4'b0001);
    check("jump_y_const", int'(y_blue), 98);
    check("jump_vy_const", int'(vy), 11);
    check("jump_st_const", int'(state), c_RISE);
    do_tick("bump", 0, 0, 0, 4'b0010);
    check("bump_st_const", int'(state), c_FALL);
    check("bump_y_const", int'(y_blue), 98);

    // Fall all the way to the screen floor, then held jump re-triggers
    for (int i = 0; i < 60 && ms != c_GROUND; i++) do_tick("to_floor", 0, 0, 0, 4'b0000);
    check("floor_y_const", int'(y_blue), 439);
    for (int i = 0; i < 40; i++) do_tick("held_jump", 0, 0, 1, 4'b0000);

    // Settle on ground
    for (int i = 0; i < 60 && ms != c_GROUND; i++) do_tick("settle", 0, 0, 0, 4'b0001);
    check("settle_st", int'(state), c_GROUND);

    // Walk right up to the wall
    for (int i = 0; i < 400 && mx < 592; i++) do_tick("walk_r", 0, 1, 0, 4'b0001);
    check("walk_r_x_const", int'(x_blue), 592);
    for (int i = 0; i < 3; i++) do_tick("blocked_r", 0, 1, 0, 4'b0101);
    check("blocked_r_x_const", int'(x_blue), 592);
    do_tick("clamp_r1", 0, 1, 0, 4'b0001);
    check("clamp_r1_const", int'(x_blue), 593);
    do_tick("clamp_r2", 0, 1, 0, 4'b0001);
    check("clamp_r2_const", int'(x_blue), 593);

    // Both keys held: no movement
    for (int i = 0; i < 10; i++) do_tick("both_keys", 1, 1, 0, 4'b0001);
    check("both_keys_const", int'(x_blue), 593);

    // Walk left down to the left limit, no wrap
    for (int i = 0; i < 400 && mx > 0; i++) do_tick("walk_l", 1, 0, 0, 4'b0001);
    do_tick("clamp_l", 1, 0, 0, 4'b0001);
    check("clamp_l_const", int'(x_blue), 0);
    do_tick("walk_r_from0", 0, 1, 0, 4'b0001);
    do_tick("blocked_l", 1, 0, 0, 4'b1001);
    check("blocked_l_const", int'(x_blue), 2);

    // No tick for 50 clocks while inputs wiggle: everything holds
    hold = '{mx, my, ms, mvy};
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      key_left = 1'($urandom); key_right = 1'($urandom);
      key_jump = 1'($urandom); is_Collision = 4'($urandom);
    end
    @(posedge clk); #1;
    compare_outputs("no_tick_hold", hold);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      bit [3:0] col;
      col = 4'($urandom);
      col[0] = ($urandom_range(0, 3) == 0);
      col[1] = ($urandom_range(0, 5) == 0);
      do_tick("rand", 1'($urandom), 1'($urandom), 1'($urandom), col);
    end

    // Asynchronous reset in the middle of a jump
    for (int i = 0; i < 60 && ms != c_GROUND; i++) do_tick("pre_rst", 0, 0, 0, 4'b0001);
    do_tick("rst_jump", 0, 1, 1, 4'b0001);
    check("rst_jump_st", int'(state), c_RISE);
    #3; rst = 1'b1;
    #1;
    compare_outputs("async_rst", '{40, 100, c_FALL, 0});
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    compare_outputs("post_rst_hold", '{40, 100, c_FALL, 0});
    do_tick("post_rst_fall", 0, 0, 0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
